// File: rtl/cpu_clk_switch_ctrl.sv
// cpu_clk_switch_ctrl
//   Sequences every change of the CPU clock source, which covers both the slow/turbo
//   switch and the jumper frequency select. The raw switch/jumper vector is synchronised
//   and debounced. The controller then waits for PLL lock (when the target needs it) and
//   for an idle 68k bus. It raises CLK_HOLD, loads the one-hot DCS selects, lets the
//   clock settle, and releases CLK_HOLD, so the CPU clock never changes mid-cycle.
// Ports
//   C7M               in   1  clock (7.09 MHz)
//   RESET_n           in   1  synchronous, active-low reset
//   CPU_SPEED_SWITCH  in   1  1 = slow (C7M), 0 = turbo; asynchronous, bouncy
//   JP2, JP3, JP4     in   1  frequency select {JP2,JP3,JP4}; asynchronous
//   AS_CPU_n          in   1  CPU address strobe
//   DTACK_CPU_n       in   1  CPU data acknowledge
//   PLL_LOCK          in   1  AND of both PLL lock outputs; asynchronous
//   CLKSEL0           out  4  one-hot DCS0 select (C7M/C14M/C21M/C28M)
//   CLKSEL1           out  4  one-hot DCS1 select (C33M/C42M/C50M/OSC)
//   TURBO_SEL         out  1  1 = turbo clock taken from DCS1, 0 = from DCS0
//   CPU_SLOW          out  1  1 = CPU runs on C7M directly
//   CLK_HOLD          out  1  1 = CPU clock held while the source changes
//   BUSY              out  1  1 = a change sequence is in progress
module cpu_clk_switch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IDLE_CYCLES     = 2,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic       C7M,
  input  logic       RESET_n,
  input  logic       CPU_SPEED_SWITCH,
  input  logic       JP2,
  input  logic       JP3,
  input  logic       JP4,
  input  logic       AS_CPU_n,
  input  logic       DTACK_CPU_n,
  input  logic       PLL_LOCK,
  output logic [3:0] CLKSEL0,
  output logic [3:0] CLKSEL1,
  output logic       TURBO_SEL,
  output logic       CPU_SLOW,
  output logic       CLK_HOLD,
  output logic       BUSY
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IC_W = $clog2(IDLE_CYCLES + 1);
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

  // {slow, sel[2:0]} as seen at power-up: slow mode, select 000
  localparam logic [3:0] RESET_VEC = 4'b1000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_WAIT_BUS  = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_SWITCH    = 3'd4;
  localparam logic [2:0] ST_SETTLE    = 3'd5;

  // Turbo targets other than select 000 and 111 are fed by a PLL output.
  function automatic logic need_pll(input logic [3:0] tgt);
    return (tgt[3] == 1'b0) && (tgt[2:0] != 3'b000) && (tgt[2:0] != 3'b111);
  endfunction

  function automatic logic [3:0] sel_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  logic [3:0]      raw_vec;
  logic [3:0]      vec_meta_r;
  logic [3:0]      vec_sync_r;
  logic [3:0]      vec_prev_r;
  logic [3:0]      stable_r;
  logic [3:0]      applied_r;
  logic [3:0]      tgt_r;
  logic            lock_meta_r;
  logic            lock_sync_r;
  logic            as_meta_r;
  logic            as_sync_r;
  logic            dtack_meta_r;
  logic            dtack_sync_r;
  logic            bus_idle;
  logic [DB_W-1:0] db_cnt_r;
  logic [IC_W-1:0] idle_cnt_r;
  logic [SC_W-1:0] settle_cnt_r;
  logic [2:0]      state_r;

  assign raw_vec  = {CPU_SPEED_SWITCH, JP2, JP3, JP4};
  assign bus_idle = as_sync_r & dtack_sync_r;

  // Two-flop synchronisers for every asynchronous input.
  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      vec_meta_r   <= RESET_VEC;
      vec_sync_r   <= RESET_VEC;
      lock_meta_r  <= 1'b0;
      lock_sync_r  <= 1'b0;
      as_meta_r    <= 1'b1;
      as_sync_r    <= 1'b1;
      dtack_meta_r <= 1'b1;
      dtack_sync_r <= 1'b1;
    end else begin
      vec_meta_r   <= raw_vec;
      vec_sync_r   <= vec_meta_r;
      lock_meta_r  <= PLL_LOCK;
      lock_sync_r  <= lock_meta_r;
      as_meta_r    <= AS_CPU_n;
      as_sync_r    <= as_meta_r;
      dtack_meta_r <= DTACK_CPU_n;
      dtack_sync_r <= dtack_meta_r;
    end
  end

  // Debounce: count consecutive equal samples; a vector is accepted once it has
  // matched its previous sample DEBOUNCE_CYCLES times in a row.
  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      vec_prev_r <= RESET_VEC;
      db_cnt_r   <= '0;
      stable_r   <= RESET_VEC;
    end else begin
      vec_prev_r <= vec_sync_r;
      if (vec_sync_r != vec_prev_r) begin
        db_cnt_r <= '0;
      end else begin
        if (db_cnt_r != DB_MAX) begin
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end
        if (db_cnt_r >= DB_LAST) begin
          stable_r <= vec_sync_r;
        end
      end
    end
  end

  // Change sequencer; all outputs are registered here.
  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      state_r      <= ST_IDLE;
      tgt_r        <= RESET_VEC;
      applied_r    <= RESET_VEC;
      idle_cnt_r   <= '0;
      settle_cnt_r <= '0;
      CLKSEL0      <= 4'b0001;
      CLKSEL1      <= 4'b0001;
      TURBO_SEL    <= 1'b0;
      CPU_SLOW     <= 1'b1;
      CLK_HOLD     <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // tgt is captured only here, so changes while busy wait for the next pass
          if (stable_r != applied_r) begin
            tgt_r   <= stable_r;
            state_r <= ST_WAIT_LOCK;
            BUSY    <= 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // lock is only checked on entry; a later loss of lock is ignored
          if (!(need_pll(tgt_r) && !lock_sync_r)) begin
            state_r    <= ST_WAIT_BUS;
            idle_cnt_r <= '0;
          end
        end
        ST_WAIT_BUS: begin
          if (!bus_idle) begin
            idle_cnt_r <= '0;
          end else if (idle_cnt_r == IC_LAST) begin
            state_r  <= ST_HOLD;
            CLK_HOLD <= 1'b1;
          end else begin
            idle_cnt_r <= idle_cnt_r + IC_W'(1);
          end
        end
        ST_HOLD: begin
          // Selects are loaded on the edge entering SWITCH, so they change one edge
          // after CLK_HOLD rises and are already stable throughout SWITCH.
          if (tgt_r[2]) begin
            CLKSEL1 <= sel_onehot(tgt_r[1:0]);
          end else begin
            CLKSEL0 <= sel_onehot(tgt_r[1:0]);
          end
          TURBO_SEL <= tgt_r[2];
          CPU_SLOW  <= tgt_r[3];
          applied_r <= tgt_r;
          state_r   <= ST_SWITCH;
        end
        ST_SWITCH: begin
          settle_cnt_r <= '0;
          state_r      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SC_LAST) begin
            state_r  <= ST_IDLE;
            CLK_HOLD <= 1'b0;
            BUSY     <= 1'b0;
          end else begin
            settle_cnt_r <= settle_cnt_r + SC_W'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          CLK_HOLD <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_switch_ctrl.sv
// tb_cpu_clk_switch_ctrl
//   Directed and randomised stimulus for cpu_clk_switch_ctrl. A small reference model
//   tracks which target is applied and what the DCS selects must read. The bench
//   measures the latency and width of each CLK_HOLD window in clock edges after a stimulus
//   change.
module tb_cpu_clk_switch_ctrl;

  localparam int DEB    = 16;
  localparam int IDLE_C = 2;
  localparam int SETTLE = 8;
  // edges from an input change to the observable events, built from the sequence rules:
  // 2 synchroniser stages, 1 edge to see the change, DEB equal samples, then
  // 1 edge IDLE->WAIT_LOCK, 1 edge WAIT_LOCK->WAIT_BUS, IDLE_C idle samples
  localparam int LAT_STABLE = 2 + 1 + DEB;
  localparam int LAT_BUSY   = LAT_STABLE + 1;
  localparam int LAT_HOLD   = LAT_STABLE + 2 + IDLE_C;
  localparam int HOLD_LEN   = SETTLE + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic [2:0] jp;
  logic       as_n;
  logic       dtack_n;
  logic       lock;
  logic [3:0] clksel0;
  logic [3:0] clksel1;
  logic       turbo_sel;
  logic       cpu_slow;
  logic       clk_hold;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // window measurement results
  int w_busy_rise;
  int w_hold_rise;
  int w_out_change;
  int w_hold_len;
  int w_pulses;

  // reference model
  logic [3:0] m_applied;
  logic [3:0] m_sel0;
  logic [3:0] m_sel1;
  logic       m_turbo;
  logic       m_slow;
  logic [3:0] onehot_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  cpu_clk_switch_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .IDLE_CYCLES(IDLE_C),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .C7M(clk),
    .RESET_n(rst_n),
    .CPU_SPEED_SWITCH(sw),
    .JP2(jp[2]),
    .JP3(jp[1]),
    .JP4(jp[0]),
    .AS_CPU_n(as_n),
    .DTACK_CPU_n(dtack_n),
    .PLL_LOCK(lock),
    .CLKSEL0(clksel0),
    .CLKSEL1(clksel1),
    .TURBO_SEL(turbo_sel),
    .CPU_SLOW(cpu_slow),
    .CLK_HOLD(clk_hold),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_applied = 4'b1000;
    m_sel0    = 4'b0001;
    m_sel1    = 4'b0001;
    m_turbo   = 1'b0;
    m_slow    = 1'b1;
  endtask

  // target is {slow, sel[2:0]}; sel[2] chooses the bank, sel[1:0] the bank input
  task automatic model_apply(input logic [3:0] t);
    if (t[2]) m_sel1 = onehot_tab[t[1:0]];
    else      m_sel0 = onehot_tab[t[1:0]];
    m_turbo   = t[2];
    m_slow    = t[3];
    m_applied = t;
  endtask

  function automatic logic model_need_pll(input logic [3:0] t);
    int sel;
    sel = int'(t[2:0]);
    return (t[3] == 1'b0) && (sel != 0) && (sel != 7);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".clksel0"}, 32'(clksel0), 32'(m_sel0));
    check({tag, ".clksel1"}, 32'(clksel1), 32'(m_sel1));
    check({tag, ".turbo"},   32'(turbo_sel), 32'(m_turbo));
    check({tag, ".slow"},    32'(cpu_slow), 32'(m_slow));
    check({tag, ".busy"},    32'(busy), 32'(1'b0));
    check({tag, ".hold"},    32'(clk_hold), 32'(1'b0));
  endtask

  // Steps n edges; cycle c is sampled 1 time unit after the c-th edge of the window.
  task automatic run_window(input int n);
    logic [9:0] snap;
    logic       prev_hold;
    w_busy_rise  = -1;
    w_hold_rise  = -1;
    w_out_change = -1;
    w_hold_len   = 0;
    w_pulses     = 0;
    snap      = {clksel0, clksel1, turbo_sel, cpu_slow};
    prev_hold = clk_hold;
    for (int c = 1; c <= n; c++) begin
      step();
      if (busy && w_busy_rise < 0) w_busy_rise = c;
      if (clk_hold) w_hold_len++;
      if (clk_hold && !prev_hold) begin
        w_pulses++;
        if (w_hold_rise < 0) w_hold_rise = c;
      end
      if ({clksel0, clksel1, turbo_sel, cpu_slow} != snap && w_out_change < 0) w_out_change = c;
      prev_hold = clk_hold;
    end
  endtask

  task automatic check_full_seq(input string tag);
    check({tag, ".busy_rise"},  32'(w_busy_rise), 32'(LAT_BUSY));
    check({tag, ".hold_rise"},  32'(w_hold_rise), 32'(LAT_HOLD));
    check({tag, ".out_change"}, 32'(w_out_change), 32'(LAT_HOLD + 1));
    check({tag, ".hold_len"},   32'(w_hold_len), 32'(HOLD_LEN));
    check({tag, ".pulses"},     32'(w_pulses), 32'(1));
  endtask

  initial begin
    logic [3:0] tgt;
    logic [3:0] tgt_b;
    logic       lk;
    logic       stall;
    int         hold_seen;

    // 1: reset with slow switch and JP=000 held
    rst_n = 1'b0; sw = 1'b1; jp = 3'b000; as_n = 1'b1; dtack_n = 1'b1; lock = 1'b1;
    model_reset();
    step(); step(); step();
    check_outputs("reset");
    rst_n = 1'b1;
    run_window(40);
    check("idle.busy_rise", 32'(w_busy_rise), 32'(-1));
    check("idle.pulses", 32'(w_pulses), 32'(0));
    check_outputs("idle");

    // 2: switch to turbo with JP=011
    tgt = 4'b0011;
    {sw, jp} = tgt;
    run_window(45);
    check_full_seq("turbo011");
    model_apply(tgt);
    check_outputs("turbo011");
    check("turbo011.clksel0_const", 32'(clksel0), 32'(4'b1000));

    // 3: switch glitch of 10 cycles is rejected
    sw = 1'b1;
    run_window(10);
    check("glitch.busy_a", 32'(w_busy_rise), 32'(-1));
    sw = 1'b0;
    run_window(40);
    check("glitch.busy_b", 32'(w_busy_rise), 32'(-1));
    check("glitch.pulses", 32'(w_pulses), 32'(0));
    check_outputs("glitch");

    // 4: PLL target waits for lock with no hold
    lock = 1'b0;
    tgt = 4'b0110;
    {sw, jp} = tgt;
    run_window(50);
    check("nolock.busy_rise", 32'(w_busy_rise), 32'(LAT_BUSY));
    check("nolock.pulses", 32'(w_pulses), 32'(0));
    check("nolock.busy", 32'(busy), 32'(1'b1));
    lock = 1'b1;
    run_window(40);
    check("lock.hold_rise", 32'(w_hold_rise), 32'(2 + 1 + IDLE_C));
    check("lock.hold_len", 32'(w_hold_len), 32'(HOLD_LEN));
    model_apply(tgt);
    check_outputs("lock");
    check("lock.clksel1_const", 32'(clksel1), 32'(4'b0100));

    // back-to-back: a second change while busy is taken after return to IDLE
    tgt = 4'b0001;
    tgt_b = 4'b1101;
    {sw, jp} = tgt;
    run_window(22);
    check("b2b.busy_rise", 32'(w_busy_rise), 32'(LAT_BUSY));
    {sw, jp} = tgt_b;
    run_window(60);
    check("b2b.pulses", 32'(w_pulses), 32'(2));
    check("b2b.hold_len", 32'(w_hold_len), 32'(2 * HOLD_LEN));
    model_apply(tgt);
    model_apply(tgt_b);
    check_outputs("b2b");

    // 5: busy bus holds off CLK_HOLD until IDLE_C idle samples
    tgt = 4'b0010;
    {sw, jp} = tgt;
    hold_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (clk_hold) hold_seen++;
      as_n = logic'(c % 2);
    end
    check("busbusy.hold", 32'(hold_seen), 32'(0));
    check("busbusy.busy", 32'(busy), 32'(1'b1));
    step();
    as_n = 1'b0;
    step();
    as_n = 1'b1;
    run_window(30);
    check("busidle.hold_rise", 32'(w_hold_rise), 32'(2 + IDLE_C));
    check("busidle.out_change", 32'(w_out_change), 32'(3 + IDLE_C));
    check("busidle.hold_len", 32'(w_hold_len), 32'(HOLD_LEN));
    model_apply(tgt);
    check_outputs("busidle");

    // 6: reset during SETTLE aborts, then the sequence re-runs
    tgt = 4'b0101;
    {sw, jp} = tgt;
    run_window(LAT_HOLD + 4);
    check("rstsettle.hold_rise", 32'(w_hold_rise), 32'(LAT_HOLD));
    check("rstsettle.hold_pre", 32'(clk_hold), 32'(1'b1));
    rst_n = 1'b0;
    step();
    model_reset();
    check_outputs("rstsettle");
    rst_n = 1'b1;
    run_window(45);
    check_full_seq("rerun");
    model_apply(tgt);
    check_outputs("rerun");

    // randomised targets and lock conditions
    for (int it = 0; it < 14; it++) begin
      tgt = 4'($urandom_range(0, 15));
      lk  = ($urandom_range(0, 3) != 0);
      {sw, jp} = tgt;
      lock = lk;
      stall = (tgt != m_applied) && model_need_pll(tgt) && !lk;
      run_window(stall ? 50 : 45);
      if (tgt == m_applied) begin
        check("rnd.nochange_busy", 32'(w_busy_rise), 32'(-1));
        check("rnd.nochange_pulses", 32'(w_pulses), 32'(0));
      end else if (stall) begin
        check("rnd.stall_busy", 32'(w_busy_rise), 32'(LAT_BUSY));
        check("rnd.stall_pulses", 32'(w_pulses), 32'(0));
        lock = 1'b1;
        run_window(40);
        check("rnd.stall_hold_rise", 32'(w_hold_rise), 32'(2 + 1 + IDLE_C));
        check("rnd.stall_out_change", 32'(w_out_change), 32'(2 + 2 + IDLE_C));
        check("rnd.stall_hold_len", 32'(w_hold_len), 32'(HOLD_LEN));
        model_apply(tgt);
      end else begin
        check_full_seq("rnd.seq");
        model_apply(tgt);
      end
      lock = 1'b1;
      check_outputs("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
